// File: rtl/id_imm_stage.sv
// ============================================================================
//  Module   : id_imm_stage
//  Brief    : Decode stage with a 2-entry skid buffer that classifies the RV32IM
//             format and presents the raw, right-aligned immediate field.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_imm_stage #(
    parameter int XLEN  = 32,
    parameter int IMM_W = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [IMM_W-1:0] imm_raw,
    output logic [2:0]       imm_sel,
    output logic             illegal
);

    localparam logic [2:0] c_sel_none = 3'd0;
    localparam logic [2:0] c_sel_i    = 3'd1;
    localparam logic [2:0] c_sel_s    = 3'd2;
    localparam logic [2:0] c_sel_b    = 3'd3;
    localparam logic [2:0] c_sel_u    = 3'd4;
    localparam logic [2:0] c_sel_j    = 3'd5;
    localparam logic [2:0] c_sel_ill  = 3'd7;

    logic             r_main_valid;
    logic [XLEN-1:0]  r_main_instr;
    logic [XLEN-1:0]  r_main_pc;
    logic [IMM_W-1:0] r_main_imm;
    logic [2:0]       r_main_sel;
    logic             r_main_ill;

    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_instr;
    logic [XLEN-1:0]  r_skid_pc;
    logic [IMM_W-1:0] r_skid_imm;
    logic [2:0]       r_skid_sel;
    logic             r_skid_ill;

    logic [IMM_W-1:0] w_dec_imm;
    logic [2:0]       w_dec_sel;
    logic             w_dec_ill;
    logic             w_in_fire;
    logic             w_main_free;

    // Only the incoming instruction is decoded; the skid entry carries its
    // decode along so a skid-to-main move needs no second decoder.
    always_comb begin
        w_dec_imm = '0;
        w_dec_sel = c_sel_none;
        w_dec_ill = 1'b0;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                w_dec_sel       = c_sel_i;
                w_dec_imm[11:0] = in_instr[31:20];
            end
            7'b0100011: begin
                w_dec_sel       = c_sel_s;
                w_dec_imm[11:0] = {in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                w_dec_sel       = c_sel_b;
                w_dec_imm[12:0] = {in_instr[31], in_instr[7], in_instr[30:25],
                                   in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_dec_sel       = c_sel_u;
                w_dec_imm[19:0] = in_instr[31:12];
            end
            7'b1101111: begin
                w_dec_sel       = c_sel_j;
                w_dec_imm[20:0] = {in_instr[31], in_instr[19:12], in_instr[20],
                                   in_instr[30:21], 1'b0};
            end
            7'b0110011, 7'b0001111: begin
                w_dec_sel = c_sel_none;
            end
            default: begin
                w_dec_sel = c_sel_ill;
                w_dec_ill = 1'b1;
            end
        endcase
    end

    assign w_in_fire   = in_valid & in_ready;
    assign w_main_free = ~r_main_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_instr <= '0;
            r_main_pc    <= '0;
            r_main_imm   <= '0;
            r_main_sel   <= c_sel_none;
            r_main_ill   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_skid_imm   <= '0;
            r_skid_sel   <= c_sel_none;
            r_skid_ill   <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                // Skid is older than anything arriving, so it advances first.
                r_main_valid <= 1'b1;
                r_main_instr <= r_skid_instr;
                r_main_pc    <= r_skid_pc;
                r_main_imm   <= r_skid_imm;
                r_main_sel   <= r_skid_sel;
                r_main_ill   <= r_skid_ill;
                r_skid_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_skid_instr <= in_instr;
                    r_skid_pc    <= in_pc;
                    r_skid_imm   <= w_dec_imm;
                    r_skid_sel   <= w_dec_sel;
                    r_skid_ill   <= w_dec_ill;
                end
            end else begin
                r_main_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_main_instr <= in_instr;
                    r_main_pc    <= in_pc;
                    r_main_imm   <= w_dec_imm;
                    r_main_sel   <= w_dec_sel;
                    r_main_ill   <= w_dec_ill;
                end
            end
        end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
            r_skid_instr <= in_instr;
            r_skid_pc    <= in_pc;
            r_skid_imm   <= w_dec_imm;
            r_skid_sel   <= w_dec_sel;
            r_skid_ill   <= w_dec_ill;
        end
    end

    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_instr = r_main_instr;
    assign out_pc    = r_main_pc;
    assign imm_raw   = r_main_imm;
    assign imm_sel   = r_main_sel;
    assign illegal   = r_main_ill;

endmodule

`default_nettype wire
